// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 host transmitter and receiver:
//   - ps2_state_t        : transmitter FSM states
//   - DEF_* constants    : default timing and filter lengths (50 MHz clock)
//   - odd_parity()       : PS/2 parity bit for a data byte
package ps2_pkg;

    localparam int DEF_INHIBIT_CYCLES = 6000;    // 120 us clock-low request hold
    localparam int DEF_REQ_CYCLES     = 100;     // 2 us data-low overlap
    localparam int DEF_TIMEOUT_CYCLES = 750000;  // 15 ms max wait per device edge
    localparam int DEF_FILTER_LEN     = 8;       // equal samples to accept a change

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        WAIT_IDLE
    } ps2_state_t;

    // PS/2 uses odd parity: data plus parity bit hold an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter
// Conditions one raw PS/2 line: 2-flop synchronizer, then a filter that only
// accepts a new level after FILTER_LEN consecutive samples of that level.
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   line_in   in   raw line level
//   line_filt out  filtered line level (1 in reset)
//   fall      out  one-cycle flag in the cycle line_filt goes 1 -> 0
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = DEF_FILTER_LEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic line_filt,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // cnt counts consecutive synchronized samples that disagree with the
    // filtered level; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync      <= 2'b11;
            cnt       <= '0;
            line_filt <= 1'b1;
            fall      <= 1'b0;
        end else begin
            sync <= {sync[0], line_in};
            fall <= 1'b0;
            if (sync[1] == line_filt) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                cnt       <= '0;
                line_filt <= sync[1];
                fall      <= line_filt;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// PS/2 host-to-device byte transmitter. Inhibits the bus, issues the request
// (start bit), shifts 8 data bits LSB first, odd parity and stop on device
// falling edges, then checks the device ACK. Open-drain drivers are outside.
// Ports:
//   CLOCK_50   in   system clock
//   KEY0       in   asynchronous active-low reset
//   tx_valid   in   byte send request
//   tx_data    in   byte to send
//   tx_ready   out  idle; request accepted when tx_valid=1
//   tx_done    out  one-cycle pulse on acknowledged completion
//   tx_err     out  one-cycle pulse on NACK or timeout
//   ps2_clk_in in   raw PS/2 clock line
//   ps2_dat_in in   raw PS/2 data line
//   ps2_clk_oe out  1 = drive clock low
//   ps2_dat_oe out  1 = drive data low
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int REQ_CYCLES     = DEF_REQ_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
    input  logic       CLOCK_50,
    input  logic       KEY0,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int MAX_A   = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int MAX_CYC = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    logic clk_filt, clk_fall;
    logic dat_filt;
    // The transmitter never needs data-line edges; the flag exists for the receiver.
    logic dat_fall_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk       (CLOCK_50),
        .rst_n     (KEY0),
        .line_in   (ps2_clk_in),
        .line_filt (clk_filt),
        .fall      (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
        .clk       (CLOCK_50),
        .rst_n     (KEY0),
        .line_in   (ps2_dat_in),
        .line_filt (dat_filt),
        .fall      (dat_fall_unused)
    );

    ps2_state_t       state_q, state_d;
    logic [7:0]       data_q, data_d;
    logic             parity_q, parity_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic             dat_oe_q, dat_oe_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [3:0]       edge_num;
    logic [2:0]       bit_idx;

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            state_q   <= IDLE;
            data_q    <= '0;
            parity_q  <= 1'b0;
            bit_cnt_q <= '0;
            cyc_cnt_q <= '0;
            dat_oe_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            parity_q  <= parity_d;
            bit_cnt_q <= bit_cnt_d;
            cyc_cnt_q <= cyc_cnt_d;
            dat_oe_q  <= dat_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // dat_oe is registered, so every data change lands the cycle after the
    // device edge flag; the start bit stays driven from REQ until edge 1.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        parity_d  = parity_q;
        bit_cnt_d = bit_cnt_q;
        cyc_cnt_d = cyc_cnt_q + 1'b1;
        dat_oe_d  = dat_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        edge_num  = bit_cnt_q + 4'd1;
        bit_idx   = edge_num[2:0] - 3'd1;

        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                if (tx_valid) begin
                    data_d   = tx_data;
                    parity_d = odd_parity(tx_data);
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cyc_cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    state_d  = REQ;
                    dat_oe_d = 1'b1;
                end
            end
            REQ: begin
                if (cyc_cnt_q == CNT_W'(REQ_CYCLES - 1)) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (clk_fall) begin
                    cyc_cnt_d = '0;
                    bit_cnt_d = edge_num;
                    if (edge_num <= 4'd8) begin
                        dat_oe_d = ~data_q[bit_idx];
                    end else if (edge_num == 4'd9) begin
                        dat_oe_d = ~parity_q;
                    end else if (edge_num == 4'd10) begin
                        dat_oe_d = 1'b0;
                    end else if (!dat_filt) begin
                        state_d = WAIT_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else if (cyc_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_filt && dat_filt) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (clk_fall) begin
                    cyc_cnt_d = '0;
                end else if (cyc_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Every state starts its timing from zero, and IDLE never drives data.
        if (state_d != state_q || state_q == IDLE) begin
            cyc_cnt_d = '0;
        end
        if (state_d == IDLE) begin
            dat_oe_d = 1'b0;
        end
    end

    assign tx_ready   = (state_q == IDLE);
    assign tx_done    = done_q;
    assign tx_err     = err_q;
    assign ps2_clk_oe = (state_q == INHIBIT) || (state_q == REQ);
    assign ps2_dat_oe = dat_oe_q;

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 The block SHALL have the parameter INHIBIT_CYCLES, default 6000, meaning the clock-low request hold (120 us at 50 MHz).
REQ-002 The block SHALL have the parameter REQ_CYCLES, default 100, meaning the data-low overlap before clock release (2 us).
REQ-003 The block SHALL have the parameter TIMEOUT_CYCLES, default 750000, meaning the maximum wait for any device edge (15 ms).
REQ-004 The block SHALL have the parameter FILTER_LEN, default 8, meaning the consecutive equal samples needed to accept a line change.
REQ-005 Ports SHALL be as follows, with clock and reset first:
- CLOCK_50  in  1  system clock.
- KEY0  in  1  reset, asynchronous and active-low.
- tx_valid  in  1  byte send request.
- tx_data  in  8  byte to send.
- tx_ready  out  1  idle; request accepted when tx_valid=1.
- tx_done  out  1  one-cycle pulse on acknowledged completion.
- tx_err  out  1  one-cycle pulse on NACK or timeout.
- ps2_clk_in  in  1  raw PS/2 clock line.
- ps2_dat_in  in  1  raw PS/2 data line.
- ps2_clk_oe  out  1  1 = drive clock low; 0 = release.
- ps2_dat_oe  out  1  1 = drive data low; 0 = release.

Function
REQ-006 Each raw line SHALL pass through a 2-flop synchronizer, then a filter that updates the filtered value only after FILTER_LEN consecutive equal samples.
REQ-007 A device falling edge SHALL be defined as filtered clock 1->0, flagged for one cycle.
REQ-008 The FSM SHALL use the states IDLE, INHIBIT, REQ, SHIFT, WAIT_IDLE.
REQ-009 In IDLE, tx_ready=1 and both oe=0; tx_valid=1 SHALL latch tx_data and parity=~^tx_data, enter INHIBIT, and drop tx_ready the next cycle.
REQ-010 tx_valid while tx_ready=0 SHALL be ignored; the latched byte SHALL be unchanged.
REQ-011 INHIBIT: clk_oe=1, dat_oe=0 for exactly INHIBIT_CYCLES cycles, then REQ.
REQ-012 REQ: clk_oe=1, dat_oe=1 (start bit) for REQ_CYCLES cycles, then SHIFT with clk_oe=0.
REQ-013 SHIFT SHALL count falling edges n=1..11.
- n=1..8: dat_oe=~data[n-1] (LSB first).
- n=9: dat_oe=~parity.
- n=10: dat_oe=0 (stop bit).
- n=11: sample filtered data; 0 = ACK -> WAIT_IDLE; 1 = NACK -> tx_err pulse and IDLE.
REQ-014 dat_oe SHALL change only in the cycle after a falling-edge flag, and never while clk_oe=1 outside INHIBIT/REQ.
REQ-015 WAIT_IDLE SHALL wait until filtered clock=1 and data=1, then pulse tx_done and enter IDLE.
REQ-016 A cycle counter SHALL clear on state entry and on each falling edge in SHIFT/WAIT_IDLE; reaching TIMEOUT_CYCLES SHALL release both lines, pulse tx_err, and enter IDLE.
REQ-017 tx_done and tx_err SHALL be mutually exclusive and each SHALL last exactly one cycle.
REQ-018 tx_ready SHALL return to 1 in the same cycle as the done/err pulse; a new request SHALL be accepted the cycle after that.

Reset
REQ-019 KEY0=0 SHALL asynchronously force the following:
- state IDLE;
- ps2_clk_oe=0, ps2_dat_oe=0;
- tx_ready=1, tx_done=0, tx_err=0;
- counters 0;
- synchronizer and filter values 1.
REQ-020 Reset mid-transfer SHALL release both lines immediately and produce no done/err pulse.

Structure
REQ-021 The shared package ps2_pkg SHALL hold the following:
- the FSM state enum;
- default INHIBIT/REQ/TIMEOUT/FILTER constants;
- the odd-parity function.
The receiver SHALL also use ps2_pkg.
REQ-022 The sub-module ps2_line_filter (synchronizer, filter, falling-edge flag) SHALL be instantiated once per line and be reusable by the receiver.
REQ-023 The block SHALL be instantiated at top level alongside the receiver; open-drain tristates SHALL live at the top level only.

Verification
REQ-024 Send 0xED with a device model ACKing -> data bits 1,0,1,1,0,1,1,1, parity 1, stop 1, one tx_done, no tx_err.
REQ-025 Send 0x01 -> parity bit 0; send 0x00 -> parity 1; both complete with tx_done.
REQ-026 Device holds data high at edge 11 -> one tx_err, lines released, tx_ready=1.
REQ-027 Device never clocks after REQ -> tx_err exactly TIMEOUT_CYCLES cycles after SHIFT entry.
REQ-028 Assert KEY0=0 at edge 5 of 0xFF -> oe both 0 immediately, no pulses; after release, send 0xF4 succeeds.
REQ-029 tx_valid held with 0xAA during a transfer of 0x55 -> 0x55 sent, then 0xAA accepted only after tx_done.
